// File: rtl/decision_unit_pipe.sv
// Chase-decoder decision unit: picks the lowest-index correctable test pattern per codeword and
// streams its error-location bits through a tagged delay line, so one codeword streams while the next is searched.
//   state  | meaning
//   IDLE   | no codeword streaming, outputs quiet
//   STREAM | presenting one correction bit per enabled cycle
module decision_unit_pipe #(
    parameter int TP_NUM      = 8,
    parameter int TP_IDX_LEN  = 3,
    parameter int ERR_CNT_LEN = 2,
    parameter int DEG_BYPASS  = 2,
    parameter int FIFO_DEPTH  = 1023,
    parameter int CODE_LEN    = 1023,
    parameter int CNT_LEN     = 10
) (
    input  logic                          clk,
    input  logic                          in_ctr_Arst_n,
    input  logic                          in_ctr_en,
    input  logic                          in_ctr_init,
    input  logic [TP_NUM*ERR_CNT_LEN-1:0] in_tp_deg,
    input  logic [TP_NUM*ERR_CNT_LEN-1:0] in_tp_errCnt,
    input  logic [TP_NUM-1:0]             in_tp_equal,
    input  logic [TP_NUM-1:0]             in_tp_sdFlip,
    output logic [TP_IDX_LEN-1:0]         out_sel_tp_num,
    output logic                          out_sel_fail,
    output logic                          out_sel_tp_equal,
    output logic                          out_equal_valid,
    output logic [CNT_LEN-1:0]            out_bit_idx,
    output logic                          out_done,
    output logic                          out_overrun
);

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    localparam logic [ERR_CNT_LEN-1:0] DEG_BYP  = ERR_CNT_LEN'(DEG_BYPASS);
    localparam logic [CNT_LEN-1:0]     PTR_LAST = CNT_LEN'(FIFO_DEPTH - 1);
    localparam logic [CNT_LEN-1:0]     IDX_LAST = CNT_LEN'(CODE_LEN - 1);

    state_t                  state, state_nxt;
    logic [CNT_LEN-1:0]      idx_nxt;
    logic                    sel_fail;
    logic [TP_IDX_LEN-1:0]   sel_idx;
    logic [ERR_CNT_LEN-1:0]  deg_i, err_i;
    logic [TP_NUM:0]         mem [FIFO_DEPTH];
    logic [CNT_LEN-1:0]      ptr, ptr_nxt;
    logic [TP_NUM-1:0]       pop_equal;
    logic                    la_init;
    logic                    pend_valid, pend_fail, act_fail;
    logic [TP_IDX_LEN-1:0]   pend_idx, act_idx;
    logic                    last_bit;

    // Scan from the top so the lowest selectable index wins.
    always_comb begin
        sel_fail = 1'b1;
        sel_idx  = '0;
        deg_i    = '0;
        err_i    = '0;
        for (int i = TP_NUM - 1; i >= 0; i--) begin
            deg_i = in_tp_deg[i*ERR_CNT_LEN +: ERR_CNT_LEN];
            err_i = in_tp_errCnt[i*ERR_CNT_LEN +: ERR_CNT_LEN];
            if ((deg_i < DEG_BYP) || (deg_i == err_i)) begin
                sel_fail = 1'b0;
                sel_idx  = TP_IDX_LEN'(i);
            end
        end
    end

    assign ptr_nxt   = (ptr == PTR_LAST) ? '0 : ptr + 1'b1;
    assign pop_equal = mem[ptr][TP_NUM-1:0];
    // The init tag is read one slot ahead so the FSM is already in STREAM when the tagged entry pops;
    // bit k of the stream is then exactly the Chien result from k cycles after init.
    assign la_init   = (FIFO_DEPTH == 1) ? in_ctr_init : mem[ptr_nxt][TP_NUM];

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            ptr <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (in_ctr_en) begin
            mem[ptr] <= {in_ctr_init, in_tp_equal};
            ptr      <= ptr_nxt;
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            out_sel_tp_num <= '0;
            out_sel_fail   <= 1'b0;
            out_overrun    <= 1'b0;
            pend_valid     <= 1'b0;
            pend_fail      <= 1'b0;
            pend_idx       <= '0;
            act_fail       <= 1'b0;
            act_idx        <= '0;
        end else if (in_ctr_en) begin
            if (la_init) begin
                act_fail <= ~pend_valid | pend_fail;
                act_idx  <= pend_valid ? pend_idx : '0;
            end
            if (in_ctr_init) begin
                out_sel_tp_num <= sel_idx;
                out_sel_fail   <= sel_fail;
                // A slot being handed to the active side this cycle counts as free.
                if (pend_valid && !la_init) begin
                    out_overrun <= 1'b1;
                end else begin
                    pend_valid <= 1'b1;
                    pend_fail  <= sel_fail;
                    pend_idx   <= sel_idx;
                end
            end else if (la_init) begin
                pend_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
        if (!in_ctr_Arst_n) begin
            state       <= IDLE;
            out_bit_idx <= '0;
        end else begin
            state       <= state_nxt;
            out_bit_idx <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt        = state;
        idx_nxt          = out_bit_idx;
        out_equal_valid  = 1'b0;
        out_sel_tp_equal = 1'b0;
        out_done         = 1'b0;
        last_bit         = (out_bit_idx == IDX_LAST);
        if (in_ctr_en) begin
            if (state == STREAM) begin
                out_equal_valid  = 1'b1;
                out_sel_tp_equal = act_fail ? 1'b0 : (pop_equal[act_idx] ^ in_tp_sdFlip[act_idx]);
                out_done         = last_bit;
            end
            if (la_init) begin
                state_nxt = STREAM;
                idx_nxt   = '0;
            end else if (state == STREAM) begin
                if (last_bit) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = out_bit_idx + 1'b1;
                end
            end
        end
    end

endmodule
